multicycle_control: RTL and testbench

Multi-cycle main control FSM for the RISC-V core, replacing the single-cycle combinational decoder. It sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB over one shared memory port with a ready handshake and a bounded wait. It drives datapath select, write-enable and ALU-op signals, and enters a sticky FAULT state on an illegal opcode or a memory timeout.

---
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main control: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// memory port with a bounded ready wait, and parks in a sticky FAULT state on errors.
module multicycle_control #(
    parameter int MEM_TIMEOUT    = 15,
    parameter int CNT_W          = 4,
    parameter int CHECK_LOW_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel_instr,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        instr_done,
    output logic        fault,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM = 3'd4, S_WB = 3'd5, S_FAULT = 3'd7
    } state_t;

    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_OPIMM = 5'b00100;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [4:0] w_op;
    logic       w_r, w_ld, w_st, w_br, w_opimm, w_jal, w_jalr, w_lui, w_auipc;
    logic       w_low_ok, w_legal, w_cnt_max;
    logic       w_unused;

    assign w_op      = instr[6:2];
    assign w_r       = (w_op == OP_R);
    assign w_ld      = (w_op == OP_LOAD);
    assign w_st      = (w_op == OP_STORE);
    assign w_br      = (w_op == OP_BR);
    assign w_opimm   = (w_op == OP_OPIMM);
    assign w_jal     = (w_op == OP_JAL);
    assign w_jalr    = (w_op == OP_JALR);
    assign w_lui     = (w_op == OP_LUI);
    assign w_auipc   = (w_op == OP_AUIPC);
    assign w_low_ok  = (CHECK_LOW_BITS == 0) || (instr[1:0] == 2'b11);
    assign w_legal   = w_low_ok && (w_r | w_ld | w_st | w_br | w_opimm |
                                    w_jal | w_jalr | w_lui | w_auipc);
    assign w_cnt_max = (r_cnt == CNT_W'(MEM_TIMEOUT));
    assign w_unused  = &{1'b0, instr[31:7]};
    assign state     = r_state;

    // Counter is cleared on every entry to FETCH/MEM so each access gets a fresh budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (run) begin
                    r_state <= S_FETCH;
                    r_cnt   <= '0;
                end
                S_FETCH: begin
                    if (mem_ready)      r_state <= S_DECODE;
                    else if (w_cnt_max) r_state <= S_FAULT;
                    else                r_cnt   <= r_cnt + CNT_W'(1);
                end
                S_DECODE: r_state <= w_legal ? S_EXEC : S_FAULT;
                S_EXEC: begin
                    if (w_br) begin
                        r_state <= run ? S_FETCH : S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_ld || w_st) begin
                        r_state <= S_MEM;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_st) begin
                            r_state <= run ? S_FETCH : S_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_WB;
                        end
                    end else if (w_cnt_max) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    r_state <= run ? S_FETCH : S_IDLE;
                    r_cnt   <= '0;
                end
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_FAULT;
            endcase
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_sel_instr = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_sel        = 2'b00;
        reg_write     = 1'b0;
        wb_sel        = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        instr_done    = 1'b0;
        fault         = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req       = 1'b1;
                mem_sel_instr = 1'b1;
                ir_write      = mem_ready;
            end
            S_EXEC: begin
                if (w_br) begin
                    alu_op     = 2'b01;
                    pc_write   = 1'b1;
                    pc_sel     = br_taken ? 2'b01 : 2'b00;
                    instr_done = 1'b1;
                end else if (w_ld || w_st || w_jalr) begin
                    alu_src_b = 2'b01;
                end else if (w_r) begin
                    alu_op = 2'b10;
                end else if (w_opimm) begin
                    alu_src_b = 2'b01;
                    alu_op    = 2'b11;
                end else if (w_lui) begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end else if (w_auipc) begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
            end
            S_MEM: begin
                mem_req    = 1'b1;
                mem_we     = w_st;
                pc_write   = w_st && mem_ready;
                instr_done = w_st && mem_ready;
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                wb_sel     = w_ld ? 2'b01 : ((w_jal || w_jalr) ? 2'b10 : 2'b00);
                pc_sel     = w_jal ? 2'b01 : (w_jalr ? 2'b10 : 2'b00);
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: instruction-level model plans each cycle and queues expected outputs;
// a negedge monitor pops and compares against the DUT.
module tb_multicycle_control;
    logic        clk = 1'b0, rst_n = 1'b0, run = 1'b0, mem_ready = 1'b0, br_taken = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        mem_req, mem_we, mem_sel_instr, ir_write, pc_write, reg_write, instr_done, fault;
    logic [1:0]  pc_sel, wb_sel, alu_src_a, alu_src_b, alu_op;
    logic [2:0]  state;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .mem_ready(mem_ready),
        .br_taken(br_taken), .mem_req(mem_req), .mem_we(mem_we),
        .mem_sel_instr(mem_sel_instr), .ir_write(ir_write), .pc_write(pc_write),
        .pc_sel(pc_sel), .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done), .fault(fault),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic mreq, mwe, msel, irw, pcw;
        logic [1:0] pcs;
        logic rw;
        logic [1:0] wbs, asa, asb, aop;
        logic done, flt;
    } out_t;

    typedef enum logic [3:0] {K_R, K_LOAD, K_STORE, K_BR, K_OPIMM, K_JAL, K_JALR,
                              K_LUI, K_AUIPC, K_ILL} kind_t;
    typedef enum logic [2:0] {P_IDLE, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_FAULT} phase_t;
    typedef struct { out_t o; phase_t ph; int cyc; } exp_t;

    out_t act;
    assign act = {state, mem_req, mem_we, mem_sel_instr, ir_write, pc_write, pc_sel,
                  reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, instr_done, fault};

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0;
    bit   idle = 1'b1;

    function automatic logic [4:0] opc(kind_t k);
        case (k)
            K_R:     return 5'b01100;
            K_LOAD:  return 5'b00000;
            K_STORE: return 5'b01000;
            K_BR:    return 5'b11000;
            K_OPIMM: return 5'b00100;
            K_JAL:   return 5'b11011;
            K_JALR:  return 5'b11001;
            K_LUI:   return 5'b01101;
            K_AUIPC: return 5'b00101;
            default: return 5'b11111;
        endcase
    endfunction

    function automatic kind_t classify(logic [31:0] ins);
        if (ins[1:0] != 2'b11) return K_ILL;
        for (int k = 0; k < 9; k++)
            if (opc(kind_t'(k)) == ins[6:2]) return kind_t'(k);
        return K_ILL;
    endfunction

    // Expected control word for a cycle, straight from the per-state output tables.
    function automatic out_t model(phase_t ph, kind_t k, logic rdy, logic bt);
        out_t o = '0;
        case (ph)
            P_FETCH: begin o.st = 3'd1; o.mreq = 1; o.msel = 1; o.irw = rdy; end
            P_DECODE: o.st = 3'd2;
            P_EXEC: begin
                o.st = 3'd3;
                case (k)
                    K_BR:    begin o.aop = 2'b01; o.pcw = 1; o.pcs = bt ? 2'b01 : 2'b00; o.done = 1; end
                    K_LOAD, K_STORE, K_JALR: o.asb = 2'b01;
                    K_R:     o.aop = 2'b10;
                    K_OPIMM: begin o.asb = 2'b01; o.aop = 2'b11; end
                    K_LUI:   begin o.asa = 2'b10; o.asb = 2'b01; end
                    K_AUIPC: begin o.asa = 2'b01; o.asb = 2'b01; end
                    default: ;
                endcase
            end
            P_MEM: begin
                o.st = 3'd4; o.mreq = 1; o.mwe = (k == K_STORE);
                if (k == K_STORE && rdy) begin o.pcw = 1; o.done = 1; end
            end
            P_WB: begin
                o.st = 3'd5; o.rw = 1; o.pcw = 1; o.done = 1;
                o.wbs = (k == K_LOAD) ? 2'b01 : ((k == K_JAL || k == K_JALR) ? 2'b10 : 2'b00);
                o.pcs = (k == K_JAL) ? 2'b01 : ((k == K_JALR) ? 2'b10 : 2'b00);
            end
            P_FAULT: begin o.st = 3'd7; o.flt = 1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(phase_t ph, kind_t k, logic rdy, logic bt, logic r, logic rn);
        exp_t e;
        rst_n = rn; mem_ready = rdy; br_taken = bt; run = r;
        e.o = model(ph, k, rdy, bt); e.ph = ph; e.cyc = cyc;
        q.push_back(e);
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic reset_seq();
        step(P_IDLE, K_ILL, rb(), rb(), rb(), 1'b0);
        step(P_IDLE, K_ILL, rb(), rb(), rb(), 1'b0);
        step(P_IDLE, K_ILL, rb(), rb(), 1'b0, 1'b1);
        idle = 1'b1;
    endtask

    task automatic fault_tail(kind_t k);
        repeat ($urandom_range(2, 5)) step(P_FAULT, k, rb(), rb(), rb(), 1'b1);
        reset_seq();
    endtask

    // wf/wm: wait cycles before ready in FETCH/MEM; 16 or more means ready never comes.
    task automatic run_instr(logic [31:0] ins, int wf, int wm, logic bt, logic run_end, bit abort_mem);
        kind_t k = classify(ins);
        instr = ins;
        if (idle) begin
            repeat ($urandom_range(0, 2)) step(P_IDLE, k, rb(), rb(), 1'b0, 1'b1);
            step(P_IDLE, k, rb(), rb(), 1'b1, 1'b1);
        end
        for (int i = 0; i < wf && i < 16; i++) step(P_FETCH, k, 1'b0, rb(), rb(), 1'b1);
        if (wf >= 16) begin fault_tail(k); return; end
        step(P_FETCH, k, 1'b1, rb(), rb(), 1'b1);
        step(P_DECODE, k, rb(), rb(), rb(), 1'b1);
        if (k == K_ILL) begin fault_tail(k); return; end
        if (k == K_BR) begin
            step(P_EXEC, k, rb(), bt, run_end, 1'b1);
            idle = !run_end;
            return;
        end
        step(P_EXEC, k, rb(), rb(), rb(), 1'b1);
        if (k == K_LOAD || k == K_STORE) begin
            for (int i = 0; i < wm && i < 16; i++) begin
                step(P_MEM, k, 1'b0, rb(), rb(), 1'b1);
                if (abort_mem) begin reset_seq(); return; end
            end
            if (wm >= 16) begin fault_tail(k); return; end
            if (k == K_STORE) begin
                step(P_MEM, k, 1'b1, rb(), run_end, 1'b1);
                idle = !run_end;
                return;
            end
            step(P_MEM, k, 1'b1, rb(), rb(), 1'b1);
        end
        step(P_WB, k, rb(), rb(), run_end, 1'b1);
        idle = !run_end;
    endtask

    function automatic int wpick();
        int r = $urandom_range(0, 19);
        if (r < 16) return $urandom_range(0, 3);
        if (r < 19) return $urandom_range(13, 15);
        return 16;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (act !== e.o) begin
                    n_bad++;
                    $display("FAIL cyc%0d %s: got %h want %h", e.cyc, e.ph.name(), act, e.o);
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] ins;
        kind_t kk;
        @(posedge clk); #1;
        reset_seq();
        run_instr(32'h00208033, 0, 0, 1'b0, 1'b1, 1'b0);   // ADD
        run_instr(32'h0000A083, 0, 3, 1'b0, 1'b1, 1'b0);   // LW, 3 waits
        run_instr(32'h00000463, 1, 0, 1'b1, 1'b1, 1'b0);   // BEQ taken
        run_instr(32'h00000463, 0, 0, 1'b0, 1'b1, 1'b0);   // BEQ not taken
        run_instr(32'h00208033, 16, 0, 1'b0, 1'b1, 1'b0);  // fetch timeout
        run_instr(32'h0000007F, 0, 0, 1'b0, 1'b1, 1'b0);   // illegal opcode
        run_instr(32'h00000030, 0, 0, 1'b0, 1'b1, 1'b0);   // bad low bits
        run_instr(32'h0020A023, 2, 15, 1'b0, 1'b0, 1'b0);  // SW, run dropped, max wait
        run_instr(32'h0000A083, 0, 5, 1'b0, 1'b1, 1'b1);   // reset mid-MEM
        run_instr(32'h0000A083, 0, 16, 1'b0, 1'b1, 1'b0);  // MEM timeout
        repeat (300) begin
            kk = kind_t'($urandom_range(0, 9));
            if (kk != K_ILL) begin
                ins = $urandom();
                ins[6:2] = opc(kk);
                ins[1:0] = 2'b11;
            end else begin
                ins = $urandom();
                while (classify(ins) != K_ILL) ins = $urandom();
            end
            run_instr(ins, wpick(), wpick(), rb(), ($urandom_range(0, 3) != 0), 1'b0);
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
